// File: rtl/button_event_arbiter.sv
// Button event arbiter.
// Turns debounced button levels into discrete press and auto-repeat events. Each button
// owns a hold FSM and a one-deep pending slot. A round-robin arbiter moves pending events
// onto a single valid/ready stream. Events that arrive while a button's slot is still
// full are dropped, and a saturating counter records how many were lost.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   btn_level_i  debounced button levels, 1 = pressed
//   enable_i     1 = accept new events; 0 = flush pending slots and idle the hold FSMs
//   evt_valid_o  event available
//   evt_ready_i  consumer accepts the event when evt_valid_o && evt_ready_i
//   evt_id_o     index of the button that produced the event
//   evt_repeat_o 0 = initial press, 1 = auto-repeat
//   drop_cnt_o   saturating count of dropped events
module button_event_arbiter #(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned ID_W          = 2,
  parameter int unsigned CNT_W         = 25,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_level_i,
  input  logic             enable_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [ID_W-1:0]  evt_id_o,
  output logic             evt_repeat_o,
  output logic [7:0]       drop_cnt_o
);

  typedef enum logic [1:0] {StIdle, StHeld, StRepeat} hold_st_e;

  logic [N_BTN-1:0] prev_q;
  logic [N_BTN-1:0] pend_q, pend_d;
  logic [N_BTN-1:0] rep_q, rep_d;
  hold_st_e         st_q [N_BTN];
  hold_st_e         st_d [N_BTN];
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];
  logic [ID_W-1:0]  last_q, last_d;
  logic             valid_q, valid_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             orep_q, orep_d;
  logic [7:0]       drop_q, drop_d;

  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] raise, raise_rep;
  logic             free;
  logic             gnt_any;
  logic [ID_W-1:0]  gnt_idx;
  int unsigned      n_drop;
  int unsigned      drop_sum;

  // Index base+k modulo N_BTN, used for the rotating search.
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                               input int unsigned k);
    int unsigned s;
    s = int'(base) + k;
    return ID_W'(s % N_BTN);
  endfunction

  assign press = btn_level_i & ~prev_q;

  // Per-button hold FSMs.
  always_comb begin
    raise     = '0;
    raise_rep = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      if (!enable_i) begin
        st_d[i]  = StIdle;
        cnt_d[i] = '0;
      end else begin
        case (st_q[i])
          StIdle: begin
            if (press[i]) begin
              raise[i] = 1'b1;
              cnt_d[i] = '0;
              st_d[i]  = StHeld;
            end
          end
          StHeld: begin
            if (!btn_level_i[i]) begin
              st_d[i]  = StIdle;
              cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(REPEAT_DELAY - 1)) begin
              raise[i]     = 1'b1;
              raise_rep[i] = 1'b1;
              cnt_d[i]     = '0;
              st_d[i]      = StRepeat;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          StRepeat: begin
            if (!btn_level_i[i]) begin
              st_d[i]  = StIdle;
              cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(REPEAT_PERIOD - 1)) begin
              raise[i]     = 1'b1;
              raise_rep[i] = 1'b1;
              cnt_d[i]     = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          default: begin
            st_d[i]  = StIdle;
            cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Round-robin grant, searching upward from the slot after the last winner.
  always_comb begin
    free    = !valid_q || evt_ready_i;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (free && enable_i) begin
      for (int unsigned k = 1; k <= N_BTN; k++) begin
        if (!gnt_any && pend_q[wrap_idx(last_q, k)]) begin
          gnt_any = 1'b1;
          gnt_idx = wrap_idx(last_q, k);
        end
      end
    end
  end

  // Pending slots. A new event beats a grant that clears the same slot in this cycle.
  always_comb begin
    pend_d = pend_q;
    rep_d  = rep_q;
    n_drop = 0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (!enable_i) begin
        pend_d[i] = 1'b0;
        rep_d[i]  = 1'b0;
      end else if (raise[i]) begin
        if (pend_q[i] && !(gnt_any && gnt_idx == ID_W'(i))) begin
          n_drop = n_drop + 1;
        end else begin
          pend_d[i] = 1'b1;
          rep_d[i]  = raise_rep[i];
        end
      end else if (gnt_any && gnt_idx == ID_W'(i)) begin
        pend_d[i] = 1'b0;
      end
    end
    drop_sum = int'(drop_q) + n_drop;
    drop_d   = (drop_sum > 255) ? 8'hFF : 8'(drop_sum);
  end

  // Output register; it only changes when empty or being accepted.
  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    orep_d  = orep_q;
    last_d  = last_q;
    if (free) begin
      if (gnt_any) begin
        valid_d = 1'b1;
        id_d    = gnt_idx;
        orep_d  = rep_q[gnt_idx];
        last_d  = gnt_idx;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= '0;
      pend_q  <= '0;
      rep_q   <= '0;
      last_q  <= ID_W'(N_BTN - 1);
      valid_q <= 1'b0;
      id_q    <= '0;
      orep_q  <= 1'b0;
      drop_q  <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        st_q[i]  <= StIdle;
        cnt_q[i] <= '0;
      end
    end else begin
      prev_q  <= btn_level_i;
      pend_q  <= pend_d;
      rep_q   <= rep_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      orep_q  <= orep_d;
      drop_q  <= drop_d;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign evt_valid_o  = valid_q;
  assign evt_id_o     = id_q;
  assign evt_repeat_o = orep_q;
  assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
module tb_button_event_arbiter;

  localparam int N      = 4;
  localparam int DELAY  = 10;
  localparam int PERIOD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = '0;
  logic       en = 1'b0;
  logic       rdy = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_repeat;
  logic [7:0] drop_cnt;

  button_event_arbiter #(
    .N_BTN        (4),
    .ID_W         (2),
    .CNT_W        (25),
    .REPEAT_DELAY (DELAY),
    .REPEAT_PERIOD(PERIOD)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_level_i (btn),
    .enable_i    (en),
    .evt_valid_o (evt_valid),
    .evt_ready_i (rdy),
    .evt_id_o    (evt_id),
    .evt_repeat_o(evt_repeat),
    .drop_cnt_o  (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: each button tracks how long it has been held since an accepted press;
  // events fire at held time 0, DELAY, DELAY+PERIOD, DELAY+2*PERIOD, ...
  bit m_act [N];
  int m_held [N];
  bit m_prev [N];
  bit m_pend [N];
  bit m_rep [N];
  bit m_valid;
  int m_id;
  bit m_orep;
  int m_last;
  int m_drop;

  int hs_ids[$];
  int hs_reps[$];

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_held[i] = 0; m_prev[i] = 0; m_pend[i] = 0; m_rep[i] = 0;
    end
    m_valid = 0; m_id = 0; m_orep = 0; m_last = N - 1; m_drop = 0;
  endtask

  task automatic model_step(input logic [3:0] b, input logic e, input logic r);
    bit ev [N];
    bit evr [N];
    int g;
    bit free;
    for (int i = 0; i < N; i++) begin
      ev[i] = 0; evr[i] = 0;
      if (!e) begin
        m_act[i] = 0;
      end else if (m_act[i]) begin
        if (!b[i]) begin
          m_act[i] = 0;
        end else begin
          m_held[i]++;
          if (m_held[i] >= DELAY && (m_held[i] - DELAY) % PERIOD == 0) begin
            ev[i] = 1; evr[i] = 1;
          end
        end
      end else if (b[i] && !m_prev[i]) begin
        m_act[i] = 1; m_held[i] = 0; ev[i] = 1; evr[i] = 0;
      end
      m_prev[i] = b[i];
    end
    free = !m_valid || r;
    g = -1;
    if (free && e) begin
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
      end
    end
    if (free) begin
      if (g >= 0) begin
        m_valid = 1; m_id = g; m_orep = m_rep[g]; m_last = g;
      end else begin
        m_valid = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!e) begin
        m_pend[i] = 0; m_rep[i] = 0;
      end else if (ev[i]) begin
        if (m_pend[i] && g != i) begin
          if (m_drop < 255) m_drop++;
        end else begin
          m_pend[i] = 1; m_rep[i] = evr[i];
        end
      end else if (g == i) begin
        m_pend[i] = 0;
      end
    end
  endtask

  // Drive one cycle of inputs just after a falling edge, then compare on the next one.
  task automatic tick(input logic [3:0] b, input logic e, input logic r);
    btn = b; en = e; rdy = r;
    if (evt_valid && r) begin
      hs_ids.push_back(int'(evt_id));
      hs_reps.push_back(int'(evt_repeat));
    end
    model_step(b, e, r);
    @(negedge clk);
    check_eq("evt_valid", 32'(evt_valid), 32'(m_valid));
    if (m_valid) begin
      check_eq("evt_id", 32'(evt_id), 32'(m_id));
      check_eq("evt_repeat", 32'(evt_repeat), 32'(m_orep));
    end
    check_eq("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic clear_log();
    hs_ids.delete();
    hs_reps.delete();
  endtask

  initial begin
    logic [3:0] rb;
    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_valid", 32'(evt_valid), 0);
    check_eq("rst_id", 32'(evt_id), 0);
    check_eq("rst_repeat", 32'(evt_repeat), 0);
    check_eq("rst_drop", 32'(drop_cnt), 0);

    // Round robin: all four pressed at once, twice.
    clear_log();
    repeat (6) tick(4'b1111, 1, 1);
    repeat (3) tick(4'b0000, 1, 1);
    repeat (6) tick(4'b1111, 1, 1);
    repeat (4) tick(4'b0000, 1, 1);
    check_eq("rr_count", 32'(hs_ids.size()), 8);
    foreach (hs_ids[i]) begin
      check_eq("rr_order", 32'(hs_ids[i]), 32'(i % 4));
      check_eq("rr_repeat", 32'(hs_reps[i]), 0);
    end

    // Single press and release.
    clear_log();
    repeat (2) tick(4'b0000, 1, 1);
    repeat (3) tick(4'b0001, 1, 1);
    repeat (6) tick(4'b0000, 1, 1);
    check_eq("single_count", 32'(hs_ids.size()), 1);
    foreach (hs_ids[i]) begin
      check_eq("single_id", 32'(hs_ids[i]), 0);
      check_eq("single_repeat", 32'(hs_reps[i]), 0);
    end

    // Auto-repeat on button 2 held for 30 cycles.
    clear_log();
    repeat (30) tick(4'b0100, 1, 1);
    repeat (8) tick(4'b0000, 1, 1);
    check_eq("rpt_count", 32'(hs_ids.size()), 6);
    foreach (hs_ids[i]) begin
      check_eq("rpt_id", 32'(hs_ids[i]), 2);
      check_eq("rpt_flag", 32'(hs_reps[i]), (i == 0) ? 0 : 1);
    end

    // Back-pressure: three presses of button 1 with the consumer stalled.
    clear_log();
    repeat (3) begin
      repeat (3) tick(4'b0010, 1, 0);
      repeat (3) tick(4'b0000, 1, 0);
    end
    check_eq("bp_held_id", 32'(evt_id), 1);
    check_eq("bp_drop", 32'(drop_cnt), 1);
    repeat (6) tick(4'b0000, 1, 1);
    check_eq("bp_count", 32'(hs_ids.size()), 2);
    foreach (hs_ids[i]) check_eq("bp_id", 32'(hs_ids[i]), 1);

    // Enable drop while button 3 repeats and an event is stalled on the output.
    clear_log();
    repeat (16) tick(4'b1000, 1, 1);
    repeat (6) tick(4'b1000, 1, 0);
    check_eq("en_inflight", 32'(evt_valid), 1);
    repeat (5) tick(4'b1000, 0, 0);
    check_eq("en_hold_valid", 32'(evt_valid), 1);
    check_eq("en_hold_id", 32'(evt_id), 3);
    repeat (3) tick(4'b1000, 0, 1);
    clear_log();
    repeat (12) tick(4'b1000, 1, 1);
    check_eq("en_no_event", 32'(hs_ids.size()), 0);
    repeat (2) tick(4'b0000, 1, 1);

    // Asynchronous reset with an event on the output and a nonzero drop count.
    repeat (3) begin
      repeat (3) tick(4'b0001, 1, 0);
      repeat (3) tick(4'b0000, 1, 0);
    end
    check_eq("ar_pre_valid", 32'(evt_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_valid", 32'(evt_valid), 0);
    check_eq("ar_drop", 32'(drop_cnt), 0);
    m_reset();
    btn = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic with slowly changing buttons so repeats occur.
    rb = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 11) == 0) rb[i] = ~rb[i];
      end
      tick(rb, ($urandom_range(0, 99) < 96), ($urandom_range(0, 99) < 70));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
